// File: rtl/cpu_pkg.sv
// Shared types and constants for the bus-processor control unit.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_DISP  = 3'b000,
    OP_ADD   = 3'b001,
    OP_ADD_I = 3'b010,
    OP_SUB   = 3'b011,
    OP_MUL   = 3'b100,
    OP_SRL   = 3'b101,
    OP_SLL   = 3'b110,
    OP_MOV_I = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_T1,
    S_T2,
    S_MUL_WAIT,
    S_T3
  } ctrl_state_t;

  localparam logic [3:0] SEL_DIN = 4'd8;
  localparam logic [3:0] SEL_G   = 4'd9;

  localparam logic [3:0] TICK_IDLE  = 4'b0000;
  localparam logic [3:0] TICK_FETCH = 4'b0001;
  localparam logic [3:0] TICK_T1    = 4'b0010;
  localparam logic [3:0] TICK_T2    = 4'b0100;
  localparam logic [3:0] TICK_T3    = 4'b1000;

  function automatic logic [7:0] reg_onehot(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/cpu_decode.sv
// Combinational decode of (state, IR) into bus selects and raw, ungated strobes.
module cpu_decode
  import cpu_pkg::*;
(
  input  ctrl_state_t i_state,
  input  logic [8:0]  i_ir,
  output logic [3:0]  o_bus_sel,
  output logic [7:0]  o_reg_write,
  output logic        o_a_write,
  output logic        o_g_write,
  output logic        o_h_write,
  output logic [2:0]  o_alu_op,
  output logic        o_alu_start,
  output logic [3:0]  o_tick,
  output logic        o_done
);

  opcode_t    w_op;
  logic [2:0] w_rx;
  logic [2:0] w_ry;

  assign w_op = opcode_t'(i_ir[8:6]);
  assign w_rx = i_ir[5:3];
  assign w_ry = i_ir[2:0];

  always_comb begin
    o_bus_sel   = 4'd0;
    o_reg_write = 8'h00;
    o_a_write   = 1'b0;
    o_g_write   = 1'b0;
    o_h_write   = 1'b0;
    o_alu_op    = 3'd0;
    o_alu_start = 1'b0;
    o_tick      = TICK_IDLE;
    o_done      = 1'b0;
    case (i_state)
      S_IDLE:  o_tick = TICK_IDLE;
      S_FETCH: o_tick = TICK_FETCH;
      S_T1: begin
        o_tick   = TICK_T1;
        o_alu_op = w_op;
        case (w_op)
          OP_DISP: begin
            o_bus_sel = {1'b0, w_rx};
            o_h_write = 1'b1;
            o_done    = 1'b1;
          end
          OP_MOV_I: begin
            o_bus_sel   = SEL_DIN;
            o_reg_write = reg_onehot(w_rx);
            o_done      = 1'b1;
          end
          default: begin
            o_bus_sel = {1'b0, w_rx};
            o_a_write = 1'b1;
          end
        endcase
      end
      S_T2: begin
        o_tick   = TICK_T2;
        o_alu_op = w_op;
        if (w_op == OP_MUL) begin
          o_bus_sel   = {1'b0, w_ry};
          o_alu_start = 1'b1;
        end else begin
          o_bus_sel = (w_op == OP_ADD_I) ? SEL_DIN : {1'b0, w_ry};
          o_g_write = 1'b1;
        end
      end
      // G write and timeout completion depend on alu_done/counter, handled in the FSM
      S_MUL_WAIT: begin
        o_tick    = TICK_T2;
        o_bus_sel = {1'b0, w_ry};
        o_alu_op  = OP_MUL;
      end
      S_T3: begin
        o_tick      = TICK_T3;
        o_alu_op    = w_op;
        o_bus_sel   = SEL_G;
        o_reg_write = reg_onehot(w_rx);
        o_done      = 1'b1;
      end
      default: o_tick = TICK_IDLE;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit: state register, instruction register, MUL wait timer.
//   state    | meaning
//   IDLE     | waiting for run
//   FETCH    | latch din into IR
//   T1       | rX onto bus: DISP/MOV_I finish, others load A
//   T2       | rY/immediate into ALU, G written (MUL: start pulse)
//   MUL_WAIT | waiting for alu_done, bounded by MUL_MAX_WAIT cycles
//   T3       | G written back into rX
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter int MUL_MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       run,
  input  logic [8:0] din,
  input  logic       alu_done,
  output logic [3:0] bus_sel,
  output logic [7:0] reg_write,
  output logic       a_write,
  output logic       g_write,
  output logic       h_write,
  output logic [2:0] alu_op,
  output logic       alu_start,
  output logic [3:0] tick,
  output logic       done,
  output logic       err
);

  localparam int CW = $clog2(MUL_MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MUL_MAX_WAIT - 1);

  ctrl_state_t   r_state;
  ctrl_state_t   w_next;
  logic [8:0]    r_ir;
  logic [CW-1:0] r_wait_cnt;
  logic [CW-1:0] w_wait_next;
  logic          r_err;

  logic [7:0]    w_reg_write;
  logic          w_a_write;
  logic          w_g_write;
  logic          w_h_write;
  logic          w_alu_start;
  logic          w_done;
  logic          w_mul_ok;
  logic          w_timeout;
  opcode_t       w_op;

  assign w_op      = opcode_t'(r_ir[8:6]);
  assign w_mul_ok  = (r_state == S_MUL_WAIT) && alu_done;
  assign w_timeout = (r_state == S_MUL_WAIT) && !alu_done && (r_wait_cnt == WAIT_LAST);

  cpu_decode u_decode (
    .i_state     (r_state),
    .i_ir        (r_ir),
    .o_bus_sel   (bus_sel),
    .o_reg_write (w_reg_write),
    .o_a_write   (w_a_write),
    .o_g_write   (w_g_write),
    .o_h_write   (w_h_write),
    .o_alu_op    (alu_op),
    .o_alu_start (w_alu_start),
    .o_tick      (tick),
    .o_done      (w_done)
  );

  always_comb begin
    w_next      = r_state;
    w_wait_next = r_wait_cnt;
    case (r_state)
      S_IDLE:  if (run) w_next = S_FETCH;
      S_FETCH: w_next = S_T1;
      S_T1: begin
        if (w_op == OP_DISP || w_op == OP_MOV_I) w_next = run ? S_FETCH : S_IDLE;
        else                                     w_next = S_T2;
      end
      S_T2: begin
        if (w_op == OP_MUL) begin
          w_next      = S_MUL_WAIT;
          w_wait_next = '0;
        end else begin
          w_next = S_T3;
        end
      end
      S_MUL_WAIT: begin
        if (alu_done)       w_next = S_T3;
        else if (w_timeout) w_next = S_IDLE;
        else                w_wait_next = r_wait_cnt + CW'(1);
      end
      S_T3:    w_next = run ? S_FETCH : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ir       <= 9'd0;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else if (ena) begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_next;
      if (r_state == S_FETCH) r_ir <= din;
      if (w_timeout)          r_err <= 1'b1;
    end
  end

  // Strobes only count on stepping edges; selects stay visible while paused
  assign reg_write = w_reg_write & {8{ena}};
  assign a_write   = w_a_write & ena;
  assign g_write   = (w_g_write | w_mul_ok) & ena;
  assign h_write   = w_h_write & ena;
  assign alu_start = w_alu_start & ena;
  assign done      = (w_done | w_timeout) & ena;
  assign err       = r_err;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed scoreboard bench for cpu_control_fsm: expected cycle outputs queued, then compared.
module tb_cpu_control_fsm;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       run;
  logic [8:0] din;
  logic       alu_done;
  logic [3:0] bus_sel;
  logic [7:0] reg_write;
  logic       a_write;
  logic       g_write;
  logic       h_write;
  logic [2:0] alu_op;
  logic       alu_start;
  logic [3:0] tick;
  logic       done;
  logic       err;

  int checks   = 0;
  int failures = 0;
  int cnt_a, cnt_g, cnt_h, cnt_rw, cnt_done, cnt_start;
  logic [7:0] last_rw;

  logic [24:0] exp_q[$];

  cpu_control_fsm #(.MUL_MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .ena(ena), .run(run), .din(din), .alu_done(alu_done),
    .bus_sel(bus_sel), .reg_write(reg_write), .a_write(a_write), .g_write(g_write),
    .h_write(h_write), .alu_op(alu_op), .alu_start(alu_start), .tick(tick),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [24:0] mk(input logic [3:0] tk, input logic [3:0] bs,
                                     input logic [7:0] rw, input logic a, input logic g,
                                     input logic h, input logic [2:0] op, input logic st,
                                     input logic dn, input logic er);
    return {tk, bs, rw, a, g, h, op, st, dn, er};
  endfunction

  task automatic clr_counts();
    cnt_a = 0; cnt_g = 0; cnt_h = 0; cnt_rw = 0; cnt_done = 0; cnt_start = 0;
    last_rw = 8'h00;
  endtask

  task automatic cyc(input string tag, input logic rs, input logic e, input logic r,
                     input logic [8:0] d, input logic ad, input logic [24:0] x);
    logic [24:0] got;
    logic [24:0] expv;
    exp_q.push_back(x);
    rst = rs; ena = e; run = r; din = d; alu_done = ad;
    @(negedge clk);
    got  = {tick, bus_sel, reg_write, a_write, g_write, h_write, alu_op, alu_start, done, err};
    expv = exp_q.pop_front();
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s got=%07h exp=%07h", tag, got, expv);
    end
    cnt_a     += int'(a_write);
    cnt_g     += int'(g_write);
    cnt_h     += int'(h_write);
    cnt_done  += int'(done);
    cnt_start += int'(alu_start);
    if (reg_write != 8'h00) begin
      cnt_rw++;
      last_rw = reg_write;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_int(input string tag, input int got, input int expv);
    checks++;
    assert (got == expv) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, expv);
    end
  endtask

  initial begin
    clr_counts();
    rst = 1'b1; ena = 1'b0; run = 1'b0; din = 9'd0; alu_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // MOV_I r3
    cyc("s1_idle",   0, 1, 1, 9'd0,           0, mk(4'h0, 4'd0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0));
    cyc("s1_fetch",  0, 1, 0, 9'b111_011_000, 0, mk(4'h1, 4'd0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0));
    cyc("s1_t1",     0, 1, 0, 9'h005,         0, mk(4'h2, 4'd8, 8'h08, 0, 0, 0, 3'd7, 0, 1, 0));
    cyc("s1_idle2",  0, 1, 0, 9'd0,           1, mk(4'h0, 4'd0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0));

    // ADD r1,r2 then back-to-back MUL r0,r1
    cyc("s2_idle",   0, 1, 1, 9'd0,           0, mk(4'h0, 4'd0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0));
    cyc("s2_fetch",  0, 1, 0, 9'b001_001_010, 0, mk(4'h1, 4'd0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0));
    cyc("s2_t1",     0, 1, 0, 9'd0,           0, mk(4'h2, 4'd1, 8'h00, 1, 0, 0, 3'd1, 0, 0, 0));
    cyc("s2_t2",     0, 1, 0, 9'd0,           1, mk(4'h4, 4'd2, 8'h00, 0, 1, 0, 3'd1, 0, 0, 0));
    cyc("s2_t3",     0, 1, 1, 9'd0,           0, mk(4'h8, 4'd9, 8'h02, 0, 0, 0, 3'd1, 0, 1, 0));

    cyc("s3_fetch",  0, 1, 0, 9'b100_000_001, 0, mk(4'h1, 4'd0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0));
    cyc("s3_t1",     0, 1, 0, 9'd0,           0, mk(4'h2, 4'd0, 8'h00, 1, 0, 0, 3'd4, 0, 0, 0));
    cyc("s3_t2",     0, 1, 0, 9'd0,           0, mk(4'h4, 4'd1, 8'h00, 0, 0, 0, 3'd4, 1, 0, 0));
    cyc("s3_w1",     0, 1, 0, 9'd0,           0, mk(4'h4, 4'd1, 8'h00, 0, 0, 0, 3'd4, 0, 0, 0));
    cyc("s3_w2",     0, 1, 0, 9'd0,           0, mk(4'h4, 4'd1, 8'h00, 0, 0, 0, 3'd4, 0, 0, 0));
    cyc("s3_w3",     0, 1, 0, 9'd0,           1, mk(4'h4, 4'd1, 8'h00, 0, 1, 0, 3'd4, 0, 0, 0));
    cyc("s3_t3",     0, 1, 0, 9'd0,           0, mk(4'h8, 4'd9, 8'h01, 0, 0, 0, 3'd4, 0, 1, 0));
    cyc("s3_idle",   0, 1, 0, 9'd0,           0, mk(4'h0, 4'd0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0));

    // MUL r2,r5 with alu_done never arriving
    clr_counts();
    cyc("s4_idle",   0, 1, 1, 9'd0,           0, mk(4'h0, 4'd0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0));
    cyc("s4_fetch",  0, 1, 0, 9'b100_010_101, 0, mk(4'h1, 4'd0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0));
    cyc("s4_t1",     0, 1, 0, 9'd0,           0, mk(4'h2, 4'd2, 8'h00, 1, 0, 0, 3'd4, 0, 0, 0));
    cyc("s4_t2",     0, 1, 0, 9'd0,           0, mk(4'h4, 4'd5, 8'h00, 0, 0, 0, 3'd4, 1, 0, 0));
    for (int i = 1; i <= 14; i++)
      cyc("s4_wait", 0, 1, 0, 9'd0,           0, mk(4'h4, 4'd5, 8'h00, 0, 0, 0, 3'd4, 0, 0, 0));
    cyc("s4_timeout",0, 1, 1, 9'd0,           0, mk(4'h4, 4'd5, 8'h00, 0, 0, 0, 3'd4, 0, 1, 0));
    cyc("s4_idle_err",0,1, 0, 9'd0,           0, mk(4'h0, 4'd0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 1));
    chk_int("s4_no_reg_write", cnt_rw, 0);
    chk_int("s4_no_g_write", cnt_g, 0);
    chk_int("s4_done_once", cnt_done, 1);
    chk_int("s4_start_once", cnt_start, 1);

    // ADD r1,r2 single-stepped; err stays set
    clr_counts();
    cyc("s5_idle_hold", 0, 0, 1, 9'd0,           0, mk(4'h0, 4'd0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 1));
    cyc("s5_idle",      0, 1, 1, 9'd0,           0, mk(4'h0, 4'd0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 1));
    cyc("s5_fetch_hold",0, 0, 0, 9'b111_111_111, 0, mk(4'h1, 4'd0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 1));
    cyc("s5_fetch",     0, 1, 0, 9'b001_001_010, 0, mk(4'h1, 4'd0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 1));
    cyc("s5_t1_hold",   0, 0, 0, 9'd0,           0, mk(4'h2, 4'd1, 8'h00, 0, 0, 0, 3'd1, 0, 0, 1));
    cyc("s5_t1_hold2",  0, 0, 0, 9'd0,           0, mk(4'h2, 4'd1, 8'h00, 0, 0, 0, 3'd1, 0, 0, 1));
    cyc("s5_t1",        0, 1, 0, 9'd0,           0, mk(4'h2, 4'd1, 8'h00, 1, 0, 0, 3'd1, 0, 0, 1));
    cyc("s5_t2_hold",   0, 0, 0, 9'd0,           0, mk(4'h4, 4'd2, 8'h00, 0, 0, 0, 3'd1, 0, 0, 1));
    cyc("s5_t2",        0, 1, 0, 9'd0,           0, mk(4'h4, 4'd2, 8'h00, 0, 1, 0, 3'd1, 0, 0, 1));
    cyc("s5_t3_hold",   0, 0, 0, 9'd0,           0, mk(4'h8, 4'd9, 8'h00, 0, 0, 0, 3'd1, 0, 0, 1));
    cyc("s5_t3_hold2",  0, 0, 1, 9'd0,           0, mk(4'h8, 4'd9, 8'h00, 0, 0, 0, 3'd1, 0, 0, 1));
    cyc("s5_t3",        0, 1, 0, 9'd0,           0, mk(4'h8, 4'd9, 8'h02, 0, 0, 0, 3'd1, 0, 1, 1));
    cyc("s5_idle_end",  0, 1, 0, 9'd0,           0, mk(4'h0, 4'd0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 1));
    chk_int("s5_a_once", cnt_a, 1);
    chk_int("s5_g_once", cnt_g, 1);
    chk_int("s5_rw_once", cnt_rw, 1);
    chk_int("s5_done_once", cnt_done, 1);
    chk_int("s5_h_never", cnt_h, 0);
    chk_int("s5_last_rw", int'(last_rw), 2);

    // SUB r4,r6 abandoned by reset in T2, then a normal MOV_I r7
    clr_counts();
    cyc("s6_idle",      0, 1, 1, 9'd0,           0, mk(4'h0, 4'd0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 1));
    cyc("s6_fetch",     0, 1, 0, 9'b011_100_110, 0, mk(4'h1, 4'd0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 1));
    cyc("s6_t1",        0, 1, 0, 9'd0,           0, mk(4'h2, 4'd4, 8'h00, 1, 0, 0, 3'd3, 0, 0, 1));
    cyc("s6_t2_rst",    1, 1, 0, 9'd0,           0, mk(4'h4, 4'd6, 8'h00, 0, 1, 0, 3'd3, 0, 0, 1));
    cyc("s6_after_rst", 0, 1, 0, 9'd0,           0, mk(4'h0, 4'd0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0));
    cyc("s6_idle2",     0, 1, 1, 9'd0,           0, mk(4'h0, 4'd0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0));
    cyc("s6_fetch2",    0, 1, 0, 9'b111_111_000, 0, mk(4'h1, 4'd0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0));
    cyc("s6_t1_movi",   0, 1, 0, 9'h01f,         0, mk(4'h2, 4'd8, 8'h80, 0, 0, 0, 3'd7, 0, 1, 0));
    cyc("s6_end",       0, 1, 0, 9'd0,           0, mk(4'h0, 4'd0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0));
    chk_int("s6_rw_only_movi", cnt_rw, 1);
    chk_int("s6_last_rw", int'(last_rw), 128);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
Multi-cycle control unit for the 16-bit bus processor. It sequences the shared bus multiplexer, register bank r0–r7, operand register A, result register G, display register H and the ALU for all eight opcodes. It replaces the partial DISP/MOV_I decode and drives the tick pattern shown on the tick 7-segment display. It holds its own instruction register and supports single-step operation through `ena`.

Parameters:
- MUL_MAX_WAIT, 15: number of MUL_WAIT cycles allowed for `alu_done` before the instruction is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ena  in  1  step enable; the FSM advances only on edges where ena=1
- run  in  1  request to fetch the next instruction
- din  in  9  instruction word in FETCH; immediate word in T1/T2 for MOV_I/ADD_I
- alu_done  in  1  ALU multi-cycle result valid (MUL)
- bus_sel  out  4  bus mux select: 0–7 = rN, 8 = din sign-extended, 9 = G
- reg_write  out  8  one-hot write strobe for r0–r7
- a_write  out  1  write A from bus
- g_write  out  1  write G from ALU
- h_write  out  1  write H from bus
- alu_op  out  3  opcode presented to ALU (equals IR[8:6] during execute)
- alu_start  out  1  one-cycle MUL start pulse
- tick  out  4  one-hot phase for display
- done  out  1  one-cycle pulse in the final cycle of every instruction
- err  out  1  sticky MUL timeout flag

Behaviour:
- Instruction fields: opcode = IR[8:6], rX = IR[5:3], rY = IR[2:0]. Opcodes: DISP 000, ADD 001, ADD_I 010, SUB 011, MUL 100, SRL 101, SLL 110, MOV_I 111.
- States and tick encoding:
  - IDLE: tick 0000
  - FETCH: tick 0001
  - T1: tick 0010
  - T2: tick 0100
  - MUL_WAIT: tick 0100
  - T3: tick 1000
- Reset (rst=1 at a clock edge): state = IDLE, IR = 0, wait counter = 0, err = 0. All strobes, alu_start and done read 0 in the following cycle. Reset mid-instruction abandons the instruction with no further writes.
- ena=0: state, IR and wait counter hold. reg_write, a_write, g_write, h_write, alu_start and done are forced to 0. bus_sel and alu_op keep their decoded values.
- All outputs are combinational from state and IR. Each write strobe is asserted in exactly one ena=1 cycle.
- IDLE: if run=1, go to FETCH; otherwise stay.
- FETCH: IR <= din at the edge; go to T1.
- DISP, T1: bus_sel = rX, h_write = 1, done = 1. Next state per the run rule.
- MOV_I, T1: bus_sel = 8, reg_write[rX] = 1, done = 1.
- ADD/ADD_I/SUB/SRL/SLL/MUL, T1: bus_sel = rX, a_write = 1; go to T2.
- T2, non-MUL: bus_sel = rY (8 for ADD_I), alu_op = opcode, g_write = 1; go to T3. SRL/SLL shift A by rY[3:0].
- T2, MUL: bus_sel = rY, alu_start = 1, wait counter = 0; go to MUL_WAIT.
- MUL_WAIT: bus_sel = rY, alu_op = MUL.
  - alu_done=1: g_write = 1 in that cycle; go to T3.
  - Otherwise the counter increments. When the counter reaches MUL_MAX_WAIT with alu_done still 0: set err, done = 1, go to IDLE. No rX write occurs.
- T3: bus_sel = 9, reg_write[rX] = 1, done = 1.
- After done: go to FETCH if run=1, else IDLE. Back-to-back instructions therefore have no idle gap.
- alu_done outside MUL_WAIT is ignored.
- err clears only on rst.

Decomposition:
- Package `cpu_pkg` holds:
  - `opcode_t` (as above)
  - `ctrl_state_t`
  - bus select constants SEL_DIN = 4'd8 and SEL_G = 4'd9
  - tick encodings
- Sub-module `cpu_decode`: combinational (state, IR) → strobe/select outputs, before ena gating. The FSM next-state logic, IR and counter stay in `cpu_control_fsm`.

Test Plan:
1. Reset, then run=1, din=9'b111_011_000 (MOV_I r3) with din=0x005 in T1 → FETCH→T1; bus_sel=8, reg_write=8'b0000_1000, done=1 in T1; tick 0001→0010.
2. ADD r1,r2 (9'b001_001_010) →
   - T1: bus_sel=1, a_write
   - T2: bus_sel=2, alu_op=001, g_write
   - T3: bus_sel=9, reg_write=8'h02, done
   - Exactly 4 cycles FETCH→T3.
3. MUL r0,r1 with alu_done raised 3 cycles after alu_start → alu_start is a single pulse in T2; g_write coincides with alu_done; T3 writes reg_write=8'h01; err=0.
4. MUL with alu_done never asserted, MUL_MAX_WAIT=15 → err=1 and done=1 after 15 MUL_WAIT cycles; state IDLE; reg_write never asserted.
5. ADD with ena toggling 1,0,0,1… → tick holds during ena=0; every strobe asserts exactly once overall; final register write is identical to scenario 2.
6. rst asserted in T2 of SUB → next cycle: tick=0000, all strobes 0, no T3 write; run=1 afterwards fetches normally.
